fft_frame_sched: RTL and testbench

//  Round-robin scheduler that shares one fft_1024_point core between NREQ sample sources.

---
 rtl/fft_frame_sched_pkg.sv | 27 ++
 rtl/fft_frame_sched_if.sv | 26 ++
 rtl/fft_frame_sched_rr_arbiter.sv | 35 +++
 rtl/fft_frame_sched.sv | 262 ++++++++++++++++++++++++++
 tb/tb_fft_frame_sched.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_frame_sched_pkg.sv
// fft_frame_sched_pkg: shared types and constants for the FFT frame scheduler.
// Holds the 3-bit FSM state encoding, the default frame length, the sample
// width and the round-robin pointer helper. The optional watchdog is selected
// with the FFT_SCHED_TIMEOUT_EN macro (off unless defined by the build).
package fft_frame_sched_pkg;

   localparam int SAMPLE_W  = 32;
   localparam int N_DEFAULT = 256;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_LOAD    = 3'd2,
      ST_UNLOAD  = 3'd3,
      ST_RELEASE = 3'd4
   } state_e;

   // Channel that gets top priority after channel idx finished a frame.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned nreq);
      if (idx + 32'd1 >= nreq) begin
         return 32'd0;
      end else begin
         return idx + 32'd1;
      end
   endfunction

endpackage

// File: rtl/fft_frame_sched_if.sv
// fft_frame_sched_if: handshake and data link between the frame scheduler
// (master) and one shared FFT core (slave). The imaginary input of the core
// is tied to zero at the core, so only the real sample travels here.
interface fft_frame_sched_if;
   import fft_frame_sched_pkg::*;

   logic                start;
   logic                dready;
   logic [SAMPLE_W-1:0] x_re;
   logic                ready;
   logic                done;
   logic [SAMPLE_W-1:0] re;
   logic [SAMPLE_W-1:0] im;
   logic                dl_busy;

   modport master (
      output start, dready, x_re, dl_busy,
      input  ready, done, re, im
   );

   modport slave (
      input  start, dready, x_re, dl_busy,
      output ready, done, re, im
   );

endinterface

// File: rtl/fft_frame_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Searches req starting at ptr,
// wrapping, and returns the first set bit as a one-hot grant plus its index.
// With en low nothing is granted. Shared by other core schedulers.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int CW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [CW-1:0]   ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [CW-1:0]   idx
);

   int   pos_s;
   logic hit_s;
   logic found_s;

   // First requester at or after ptr wins; each position is visited once.
   always_comb begin
      gnt     = '0;
      idx     = '0;
      pos_s   = 0;
      hit_s   = 1'b0;
      found_s = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         pos_s      = (int'(ptr) + i) % NREQ;
         hit_s      = en && !found_s && req[pos_s];
         gnt[pos_s] = hit_s;
         idx        = hit_s ? CW'(pos_s) : idx;
         found_s    = found_s | hit_s;
      end
   end

endmodule

// File: rtl/fft_frame_sched.sv
// fft_frame_sched: shares one FFT core between NREQ sample sources.
// One requester is granted per frame; N samples are streamed into the core,
// N result beats are tagged with the channel and forwarded, then the core is
// released and the round-robin pointer advances past the served channel.
// Optional watchdog on the result phase: define FFT_SCHED_TIMEOUT_EN.
module fft_frame_sched
   import fft_frame_sched_pkg::*;
#(
   parameter int N    = N_DEFAULT,
   parameter int NREQ = 2,
   parameter int CW   = 2,
   parameter int TMO  = 4096
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [NREQ-1:0]          req_i,
   input  logic [SAMPLE_W*NREQ-1:0] x_re_i,
   output logic [NREQ-1:0]          gnt_o,
   output logic [NREQ-1:0]          rd_o,
   fft_frame_sched_if.master        fft,
   input  logic                     dl_busy_i,
   output logic                     y_valid_o,
   output logic [SAMPLE_W-1:0]      y_re_o,
   output logic [SAMPLE_W-1:0]      y_im_o,
   output logic [CW-1:0]            y_ch_o,
   output logic                     y_last_o,
   output logic                     err_o
);

   localparam int CNT_W = $clog2(N);
   localparam int RCW   = CNT_W + 1;

   // Reject parameter sets the counters and arbiter are not built for.
   if (N < 8 || N > 1024 || (N & (N - 1)) != 0 || NREQ < 2 || NREQ > 4 ||
       CW < $clog2(NREQ) || TMO < 2) begin : g_bad_param
      $error("fft_frame_sched: illegal parameter set");
   end

   state_e              state_r;
   state_e              state_nx_s;
   logic [NREQ-1:0]     gnt_r;
   logic [NREQ-1:0]     rd_r;
   logic [CW-1:0]       ch_r;
   logic [CW-1:0]       ptr_r;
   logic [CNT_W-1:0]    scnt_r;
   logic [RCW-1:0]      rcnt_r;
   logic                start_r;
   logic                dready_r;
   logic [SAMPLE_W-1:0] x_re_r;
   logic                y_valid_r;
   logic                y_last_r;
   logic [SAMPLE_W-1:0] y_re_r;
   logic [SAMPLE_W-1:0] y_im_r;
   logic [CW-1:0]       y_ch_r;
   logic                err_r;
   logic                done_seen_r;

   logic [NREQ-1:0]     arb_gnt_s;
   logic [CW-1:0]       arb_idx_s;
   logic                in_frame_s;
   logic                beat_ok_s;
   logic                last_beat_s;
   logic                beats_done_s;
   logic                bad_ready_s;
   logic                early_done_s;
   logic                wd_fire_s;

   rr_arbiter #(
      .NREQ (NREQ),
      .CW   (CW)
   ) u_arb (
      .req (req_i),
      .ptr (ptr_r),
      .en  (state_r == ST_IDLE),
      .gnt (arb_gnt_s),
      .idx (arb_idx_s)
   );

   // A result beat is only legal in UNLOAD while fewer than N have arrived.
   assign in_frame_s   = state_r inside {ST_START, ST_LOAD, ST_UNLOAD};
   assign beat_ok_s    = (state_r == ST_UNLOAD) && fft.ready && (rcnt_r < RCW'(N));
   assign last_beat_s  = beat_ok_s && (rcnt_r == RCW'(N - 1));
   assign beats_done_s = (rcnt_r == RCW'(N)) || last_beat_s;
   assign bad_ready_s  = fft.ready && !beat_ok_s;
   assign early_done_s = fft.done && in_frame_s && !beats_done_s;

`ifdef FFT_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TMO + 1);
   logic [WD_W-1:0] wd_r;

   assign wd_fire_s = (state_r == ST_UNLOAD) && !fft.ready && !dl_busy_i &&
                      (wd_r == WD_W'(TMO - 1));

   // Watchdog: UNLOAD cycles since the last core beat, frozen while the sink is busy.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wd_r <= '0;
      end else if (state_r != ST_UNLOAD || fft.ready) begin
         wd_r <= '0;
      end else if (!dl_busy_i) begin
         wd_r <= wd_r + WD_W'(1);
      end else begin
         wd_r <= wd_r;
      end
   end
`else
   assign wd_fire_s = 1'b0;
`endif

   // Next-state decode for the frame sequence.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (|req_i) begin
               state_nx_s = ST_START;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_START: begin
            state_nx_s = ST_LOAD;
         end
         ST_LOAD: begin
            if (scnt_r == CNT_W'(N - 1)) begin
               state_nx_s = ST_UNLOAD;
            end else begin
               state_nx_s = ST_LOAD;
            end
         end
         ST_UNLOAD: begin
            if (wd_fire_s) begin
               state_nx_s = ST_RELEASE;
            end else if (beats_done_s && (done_seen_r || fft.done)) begin
               state_nx_s = ST_RELEASE;
            end else begin
               state_nx_s = ST_UNLOAD;
            end
         end
         ST_RELEASE: begin
            state_nx_s = ST_IDLE;
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State, grant and control strobes; strobes are registered from the next state.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r  <= ST_IDLE;
         gnt_r    <= '0;
         ch_r     <= '0;
         ptr_r    <= '0;
         start_r  <= 1'b0;
         rd_r     <= '0;
         dready_r <= 1'b0;
      end else begin
         state_r  <= state_nx_s;
         start_r  <= (state_nx_s == ST_START);
         rd_r     <= (state_nx_s == ST_LOAD) ? gnt_r : '0;
         dready_r <= |rd_r;
         if (state_r == ST_IDLE && state_nx_s == ST_START) begin
            gnt_r <= arb_gnt_s;
            ch_r  <= arb_idx_s;
         end else if (state_nx_s == ST_RELEASE || state_nx_s == ST_IDLE) begin
            gnt_r <= '0;
            ch_r  <= ch_r;
         end else begin
            gnt_r <= gnt_r;
            ch_r  <= ch_r;
         end
         if (state_r == ST_RELEASE) begin
            ptr_r <= CW'(rr_next(32'(ch_r), 32'(NREQ)));
         end else begin
            ptr_r <= ptr_r;
         end
      end
   end

   // Sample path: count LOAD cycles and register the consumed sample for the core.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         scnt_r <= '0;
         x_re_r <= '0;
      end else begin
         if (state_r == ST_LOAD) begin
            scnt_r <= scnt_r + CNT_W'(1);
         end else begin
            scnt_r <= '0;
         end
         if (|rd_r) begin
            x_re_r <= x_re_i[ch_r*SAMPLE_W +: SAMPLE_W];
         end else begin
            x_re_r <= x_re_r;
         end
      end
   end

   // Result path: forward each legal core beat one cycle later, tagged with the channel.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rcnt_r      <= '0;
         done_seen_r <= 1'b0;
         y_valid_r   <= 1'b0;
         y_last_r    <= 1'b0;
         y_re_r      <= '0;
         y_im_r      <= '0;
         y_ch_r      <= '0;
      end else begin
         y_valid_r <= beat_ok_s;
         y_last_r  <= last_beat_s;
         if (state_r == ST_START) begin
            rcnt_r <= '0;
         end else if (beat_ok_s) begin
            rcnt_r <= rcnt_r + RCW'(1);
         end else begin
            rcnt_r <= rcnt_r;
         end
         if (state_r == ST_IDLE) begin
            done_seen_r <= 1'b0;
         end else if (in_frame_s && fft.done) begin
            done_seen_r <= 1'b1;
         end else begin
            done_seen_r <= done_seen_r;
         end
         if (beat_ok_s) begin
            y_re_r <= fft.re;
            y_im_r <= fft.im;
            y_ch_r <= ch_r;
         end else begin
            y_re_r <= y_re_r;
            y_im_r <= y_im_r;
            y_ch_r <= y_ch_r;
         end
      end
   end

   // Sticky protocol error: stray beats, early done or watchdog expiry.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_r | bad_ready_s | early_done_s | wd_fire_s;
      end
   end

   assign gnt_o       = gnt_r;
   assign rd_o        = rd_r;
   assign fft.start   = start_r;
   assign fft.dready  = dready_r;
   assign fft.x_re    = x_re_r;
   assign fft.dl_busy = dl_busy_i;
   assign y_valid_o   = y_valid_r;
   assign y_re_o      = y_re_r;
   assign y_im_o      = y_im_r;
   assign y_ch_o      = y_ch_r;
   assign y_last_o    = y_last_r;
   assign err_o       = err_r;

endmodule

// File: tb/tb_fft_frame_sched.sv
// tb_fft_frame_sched: directed bench for the FFT frame scheduler. The bench
// plays the FFT core and the channel front-ends; expected samples and result
// beats come from the values the bench itself drives.
module tb_fft_frame_sched;
   import fft_frame_sched_pkg::*;

   localparam int N    = 256;
   localparam int NREQ = 2;
   localparam int CW   = 2;
   localparam int TMO  = 64;

   logic                     clk = 1'b0;
   logic                     rstn;
   logic [NREQ-1:0]          req_i;
   logic [SAMPLE_W*NREQ-1:0] x_re_i;
   logic [NREQ-1:0]          gnt_o;
   logic [NREQ-1:0]          rd_o;
   logic                     dl_busy_i;
   logic                     y_valid_o;
   logic [SAMPLE_W-1:0]      y_re_o;
   logic [SAMPLE_W-1:0]      y_im_o;
   logic [CW-1:0]            y_ch_o;
   logic                     y_last_o;
   logic                     err_o;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] sample_cnt = 32'd0;

   fft_frame_sched_if fft_if ();

   fft_frame_sched #(
      .N    (N),
      .NREQ (NREQ),
      .CW   (CW),
      .TMO  (TMO)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_i     (req_i),
      .x_re_i    (x_re_i),
      .gnt_o     (gnt_o),
      .rd_o      (rd_o),
      .fft       (fft_if),
      .dl_busy_i (dl_busy_i),
      .y_valid_o (y_valid_o),
      .y_re_o    (y_re_o),
      .y_im_o    (y_im_o),
      .y_ch_o    (y_ch_o),
      .y_last_o  (y_last_o),
      .err_o     (err_o)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Hard stop in case the design never lets the bench finish.
   initial begin
      #500000;
      $display("FAIL global_timeout: simulation time exhausted, required end of test first");
      $fatal(1, "timeout");
   end

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      tick();
   endtask

   function automatic logic [NREQ-1:0] onehot(input int ch);
      logic [NREQ-1:0] v;
      v     = '0;
      v[ch] = 1'b1;
      return v;
   endfunction

   // Wait for the start pulse, then follow the N-sample load into the core.
   task automatic load_phase(input int ch, input bit hold_req);
      int          t = 0;
      int          n_start = 0;
      int          n_rd = 0;
      int          n_dr = 0;
      int          bad = 0;
      logic [31:0] q[$];
      logic [31:0] v;
      while (fft_if.start !== 1'b1 && t < 20) begin
         tick();
         t++;
      end
      chk_eq("start_seen", 64'(t < 20), 64'd1);
      chk_eq("gnt", 64'(gnt_o), 64'(onehot(ch)));
      if (!hold_req) req_i = '0;
      for (int i = 0; i < N + 4; i++) begin
         if (fft_if.start === 1'b1) n_start++;
         if (fft_if.dready === 1'b1) begin
            n_dr++;
            if (q.size() == 0) begin
               bad++;
            end else begin
               v = q.pop_front();
               if (fft_if.x_re !== v) bad++;
            end
         end
         if (rd_o != '0) begin
            n_rd++;
            if (rd_o !== onehot(ch)) bad++;
         end
         if (gnt_o !== onehot(ch)) bad++;
         sample_cnt = sample_cnt + 32'd1;
         x_re_i = {32'hB100_0000 + sample_cnt, 32'hB000_0000 + sample_cnt};
         if (rd_o != '0) q.push_back(x_re_i[ch*SAMPLE_W +: SAMPLE_W]);
         tick();
      end
      chk_eq("start_pulses", 64'(n_start), 64'd1);
      chk_eq("rd_cycles", 64'(n_rd), 64'(N));
      chk_eq("dready_cycles", 64'(n_dr), 64'(N));
      chk_eq("load_data_errs", 64'(bad), 64'd0);
   endtask

   // Act as the core output side: N beats, done on beat done_beat, optional sink stalls.
   task automatic unload_phase(input int ch, input int done_beat, input bit busy_mode, input int frame_id);
      int               sent = 0;
      int               seen = 0;
      int               bad = 0;
      int               lasts = 0;
      int               busy_bad = 0;
      int               budget = 0;
      logic [NREQ-1:0]  last_gnt = '1;
      logic [64:0]      q[$];
      logic [64:0]      e;
      logic [31:0]      r;
      logic             rdy;
      while (seen < N && budget < 4 * N) begin
         if (y_valid_o === 1'b1) begin
            if (q.size() == 0) begin
               bad++;
            end else begin
               e = q.pop_front();
               if ({y_last_o, y_re_o, y_im_o} !== e || y_ch_o !== CW'(ch)) bad++;
            end
            if (y_last_o === 1'b1) lasts++;
            seen++;
            if (seen == N) last_gnt = gnt_o;
         end
         if (fft_if.dl_busy !== dl_busy_i) busy_bad++;
         dl_busy_i = busy_mode ? ((budget % 15) < 10) : 1'b0;
         rdy = (sent < N) && !dl_busy_i;
         r = 32'h5000_0000 + 32'(frame_id) * 32'h1000 + 32'(sent);
         fft_if.ready = rdy;
         fft_if.done  = rdy && (sent == done_beat);
         fft_if.re    = r;
         fft_if.im    = ~r;
         if (rdy) begin
            q.push_back({(sent == N - 1), r, ~r});
            sent++;
         end
         tick();
         budget++;
      end
      fft_if.ready = 1'b0;
      fft_if.done  = 1'b0;
      dl_busy_i    = 1'b0;
      chk_eq("y_beats", 64'(seen), 64'(N));
      chk_eq("y_data_errs", 64'(bad), 64'd0);
      chk_eq("y_last_count", 64'(lasts), 64'd1);
      chk_eq("release_gnt", 64'(last_gnt), 64'd0);
      if (busy_mode) chk_eq("dl_busy_follow_errs", 64'(busy_bad), 64'd0);
   endtask

   initial begin
      int t;
      int yv;
      rstn         = 1'b0;
      req_i        = '0;
      x_re_i       = '0;
      dl_busy_i    = 1'b0;
      fft_if.ready = 1'b0;
      fft_if.done  = 1'b0;
      fft_if.re    = '0;
      fft_if.im    = '0;

      // 1. Reset for two cycles: every output low; then a single channel-0 frame.
      tick();
      tick();
      chk_eq("rst_ctl", {gnt_o, rd_o, fft_if.start, fft_if.dready, fft_if.dl_busy,
                         y_valid_o, y_last_o, err_o, y_ch_o}, 64'd0);
      chk_eq("rst_data", 64'(fft_if.x_re | y_re_o | y_im_o), 64'd0);
      rstn = 1'b1;
      tick();
      req_i = 2'b01;
      load_phase(0, 1'b0);
      unload_phase(0, N - 1, 1'b0, 1);
      chk_eq("err_t1", 64'(err_o), 64'd0);

      // 2. Both channels requesting across three frames: 0, 1, 0.
      do_reset();
      req_i = 2'b11;
      load_phase(0, 1'b1);
      unload_phase(0, N - 1, 1'b0, 2);
      load_phase(1, 1'b1);
      unload_phase(1, N - 1, 1'b0, 3);
      load_phase(0, 1'b0);
      unload_phase(0, N - 1, 1'b0, 4);
      chk_eq("err_t2", 64'(err_o), 64'd0);

      // 3. Sink busy 10 cycles, free 5, throughout the result phase.
      req_i = 2'b01;
      load_phase(0, 1'b0);
      unload_phase(0, N - 1, 1'b1, 5);
      chk_eq("err_t3", 64'(err_o), 64'd0);

      // 4. Reset during LOAD cycle 100; the next frame restarts at channel 0.
      req_i = 2'b11;
      t = 0;
      while (fft_if.start !== 1'b1 && t < 20) begin
         tick();
         t++;
      end
      chk_eq("t4_start_seen", 64'(t < 20), 64'd1);
      chk_eq("t4_gnt", 64'(gnt_o), 64'(2'b10));
      repeat (101) tick();
      chk_eq("t4_rd_mid", 64'(rd_o), 64'(2'b10));
      rstn = 1'b0;
      tick();
      chk_eq("t4_abort", 64'({gnt_o, rd_o, y_valid_o}), 64'd0);
      rstn = 1'b1;
      load_phase(0, 1'b0);
      unload_phase(0, N - 1, 1'b0, 6);
      chk_eq("err_t4", 64'(err_o), 64'd0);

      // 5. done on beat 10: error flagged, all beats still forwarded; stray beat in IDLE dropped.
      req_i = 2'b01;
      load_phase(0, 1'b0);
      unload_phase(0, 10, 1'b0, 7);
      chk_eq("err_early_done", 64'(err_o), 64'd1);
      repeat (3) tick();
      fft_if.ready = 1'b1;
      fft_if.re    = 32'hDEAD_0001;
      fft_if.im    = 32'hDEAD_0002;
      tick();
      fft_if.ready = 1'b0;
      yv = 0;
      for (int i = 0; i < 3; i++) begin
         if (y_valid_o === 1'b1) yv++;
         tick();
      end
      chk_eq("idle_ready_dropped", 64'(yv), 64'd0);
      chk_eq("err_sticky", 64'(err_o), 64'd1);

`ifdef FFT_SCHED_TIMEOUT_EN
      // 6. Core stalls in UNLOAD: watchdog fires after 64 idle cycles, next requester granted.
      do_reset();
      chk_eq("err_t6_pre", 64'(err_o), 64'd0);
      req_i = 2'b11;
      load_phase(0, 1'b1);
      // load_phase returns 3 cycles into UNLOAD; the 64th stalled cycle ends 61 edges later.
      t  = 0;
      yv = 0;
      while (err_o !== 1'b1 && t < 300) begin
         if (y_valid_o === 1'b1) yv++;
         tick();
         t++;
      end
      chk_eq("wd_cycles", 64'(t), 64'd61);
      chk_eq("wd_release_gnt", 64'(gnt_o), 64'd0);
      chk_eq("wd_no_beats", 64'(yv), 64'd0);
      t = 0;
      while (fft_if.start !== 1'b1 && t < 10) begin
         tick();
         t++;
      end
      chk_eq("wd_next_start", 64'(t < 10), 64'd1);
      chk_eq("wd_next_gnt", 64'(gnt_o), 64'(2'b10));
      req_i = '0;
      do_reset();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
